// File: rtl/cla_seq_adder_if.sv
// Request/response bundle for the sequential CLA adder: operand handshake in,
// result plus NZCV flags out.
interface cla_seq_adder_if #(
  parameter int WIDTH = 64
) ();
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic             carry_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output in_valid, op, carry_in, a, b, out_ready,
    input  in_ready, out_valid, sum, flag_n, flag_z, flag_c, flag_v
  );

  modport slave (
    input  in_valid, op, carry_in, a, b, out_ready,
    output in_ready, out_valid, sum, flag_n, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/cla_seq_adder.sv
// WIDTH-bit ADD/SUB/ADC/SBC computed one 16-bit slice per clock through a single
// CLA_16bit, with the slice carry chained from the adder's group P/G outputs.

// Four-wide lookahead carry unit, shared by the bit level and the group level.
module cla_lcu4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [3:0] c,
  output logic       pg,
  output logic       gg
);
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign pg   = &p;
  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       pg,
  output logic       gg
);
  logic [3:0] p, g, c;

  assign p = a ^ b;
  assign g = a & b;

  cla_lcu4 u_lcu (.p(p), .g(g), .cin(cin), .c(c), .pg(pg), .gg(gg));

  assign s = p ^ c;
endmodule

module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        pg,
  output logic        gg
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][3:0] a_v, b_v, s_v;
  logic [NUM_LANES-1:0]      grp_p, grp_g, grp_c;

  assign a_v = a;
  assign b_v = b;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_grp
    cla_4bit u_grp (
      .a  (a_v[i]),
      .b  (b_v[i]),
      .cin(grp_c[i]),
      .s  (s_v[i]),
      .pg (grp_p[i]),
      .gg (grp_g[i])
    );
  end

  cla_lcu4 u_lcu (.p(grp_p), .g(grp_g), .cin(cin), .c(grp_c), .pg(pg), .gg(gg));

  assign s = s_v;
endmodule

module cla_seq_adder #(
  parameter int WIDTH = 64
) (
  input  logic            clk,
  input  logic            reset,
  cla_seq_adder_if.slave  bus
);
  // WIDTH must be a multiple of 16 and at least 32, so CW is never zero.
  localparam int SLICES = WIDTH / 16;
  localparam int CW     = $clog2(SLICES);
  localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            slice_q, slice_d;
  logic                     carry_q, carry_d;
  logic [SLICES-1:0][15:0]  opa_q, opa_d;
  logic [SLICES-1:0][15:0]  opb_q, opb_d;
  logic [SLICES-1:0][15:0]  sum_q, sum_d;
  logic [3:0]               nzcv_q, nzcv_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;

  logic                     accept, step, last;
  logic [15:0]              cla_s;
  logic                     cla_pg, cla_gg, carry_nxt, cin_eff, ovf;
  logic [SLICES-1:0][15:0]  sum_full;

  CLA_16bit u_cla (
    .a  (opa_q[slice_q]),
    .b  (opb_q[slice_q]),
    .cin(carry_q),
    .s  (cla_s),
    .pg (cla_pg),
    .gg (cla_gg)
  );

  assign carry_nxt = cla_gg | (cla_pg & carry_q);
  assign cin_eff   = bus.op[1] ? bus.carry_in : bus.op[0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)        state_d = RUN;
      RUN:     if (last)          state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Output / control decode; ready and valid are registered copies of the next state
  always_comb begin
    accept      = (state_q == IDLE) && bus.in_valid && in_ready_q;
    step        = (state_q == RUN);
    last        = step && (slice_q == LAST);
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // Datapath
  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    carry_d  = carry_q;
    slice_d  = slice_q;
    sum_d    = sum_q;
    nzcv_d   = nzcv_q;
    sum_full = sum_q;
    sum_full[slice_q] = cla_s;
    ovf = (opa_q[SLICES-1][15] == opb_q[SLICES-1][15]) &&
          (sum_full[SLICES-1][15] != opa_q[SLICES-1][15]);
    if (accept) begin
      opa_d   = bus.a;
      opb_d   = bus.op[0] ? ~bus.b : bus.b;
      carry_d = cin_eff;
      slice_d = '0;
    end else if (step) begin
      sum_d   = sum_full;
      carry_d = carry_nxt;
      slice_d = last ? '0 : slice_q + 1'b1;
      if (last) nzcv_d = {sum_full[SLICES-1][15], ~|sum_full, carry_nxt, ovf};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slice_q     <= '0;
      carry_q     <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      sum_q       <= '0;
      nzcv_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      slice_q     <= slice_d;
      carry_q     <= carry_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      sum_q       <= sum_d;
      nzcv_q      <= nzcv_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.flag_n    = nzcv_q[3];
  assign bus.flag_z    = nzcv_q[2];
  assign bus.flag_c    = nzcv_q[1];
  assign bus.flag_v    = nzcv_q[0];
endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder at WIDTH=64: directed cases, random ops,
// back-pressure and mid-operation reset.
module tb_cla_seq_adder;
  localparam int W = 64;

  typedef struct {
    logic [W-1:0] sum;
    logic [3:0]   nzcv;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  cla_seq_adder_if #(.WIDTH(W)) bus ();

  cla_seq_adder #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
  endfunction

  // Reference: wide add of the (possibly inverted) operand plus effective cin.
  function automatic exp_t model(input logic [1:0] op, input logic cin,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] bb;
    logic [W:0]   t;
    logic         c0;
    bb = op[0] ? ~b : b;
    c0 = op[1] ? cin : op[0];
    t  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
    e.sum  = t[W-1:0];
    e.nzcv = {t[W-1], (t[W-1:0] == '0), t[W],
              (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1])};
    return e;
  endfunction

  task automatic wait_ready(input string tag, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = bus.in_ready;
    if (!ok) chk({tag, "_ready_timeout"}, {63'b0, bus.in_ready}, 64'd1);
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic cin,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e, input int hold);
    bit   ok;
    int   lat;
    exp_t f;
    wait_ready(tag, ok);
    if (!ok) return;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.carry_in = cin;
    bus.a        = a;
    bus.b        = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    // Inputs are not held and carry_in flips after accept; neither may matter.
    bus.in_valid = 1'b0;
    bus.carry_in = ~cin;
    bus.a        = {$urandom, $urandom};
    bus.b        = {$urandom, $urandom};
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!bus.out_valid) chk({tag, "_busy_in_ready"}, {63'b0, bus.in_ready}, 64'd0);
    end while (!bus.out_valid && lat < 20);
    chk({tag, "_latency"}, W'(lat), 64'd4);
    if (!bus.out_valid) begin
      void'(sb.pop_front());
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = {$urandom, $urandom};
      @(posedge clk);
      #1;
      chk({tag, "_bp_valid"}, {63'b0, bus.out_valid}, 64'd1);
      chk({tag, "_bp_ready"}, {63'b0, bus.in_ready}, 64'd0);
      chk({tag, "_bp_sum"}, bus.sum, e.sum);
      chk({tag, "_bp_nzcv"}, {60'b0, flags()}, {60'b0, e.nzcv});
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    f = sb.pop_front();
    chk({tag, "_sum"}, bus.sum, f.sum);
    chk({tag, "_nzcv"}, {60'b0, flags()}, {60'b0, f.nzcv});
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_hs_valid"}, {63'b0, bus.out_valid}, 64'd0);
    chk({tag, "_hs_ready"}, {63'b0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b0;
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic [3:0] f);
    exp_t e;
    e.sum  = s;
    e.nzcv = f;
    return e;
  endfunction

  initial begin
    bit ok;
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    logic         rc;
    exp_t         e;

    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.carry_in  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
    chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_sum", bus.sum, 64'd0);
    chk("rst_flags", {60'b0, flags()}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready_rise", {63'b0, bus.in_ready}, 64'd1);

    do_op("add_basic", 2'b00, 1'b0, 64'h0000_0000_0000_FFFF, 64'd1,
          mk(64'h0000_0000_0001_0000, 4'b0000), 0);
    do_op("add_ripple", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
          mk(64'd0, 4'b0110), 0);
    do_op("add_ovf", 2'b00, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
          mk(64'h8000_0000_0000_0000, 4'b1001), 0);
    do_op("sub_eq", 2'b01, 1'b0, 64'd5, 64'd5, mk(64'd0, 4'b0110), 0);
    do_op("sub_borrow", 2'b01, 1'b1, 64'd0, 64'd1,
          mk(64'hFFFF_FFFF_FFFF_FFFF, 4'b1000), 0);
    do_op("sub_ovf", 2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'd1,
          mk(64'h7FFF_FFFF_FFFF_FFFF, 4'b0011), 0);
    do_op("adc", 2'b10, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd0,
          mk(64'h0000_0001_0000_0000, 4'b0000), 0);
    do_op("sbc", 2'b11, 1'b0, 64'd10, 64'd3, mk(64'd6, 4'b0010), 0);
    do_op("backpressure", 2'b00, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
          mk(64'h2222_2222_2222_2211, 4'b0000), 10);

    for (int i = 0; i < 16; i++) begin
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rop = 2'($urandom_range(0, 3));
      rc  = 1'($urandom_range(0, 1));
      if (i % 4 == 0) rb = ~ra;
      if (i % 4 == 1) rb = ra;
      e = model(rop, rc, ra, rb);
      do_op($sformatf("rnd%0d", i), rop, rc, ra, rb, e, 0);
    end

    // Reset after two slices have been written.
    wait_ready("rst_mid", ok);
    if (ok) begin
      bus.in_valid = 1'b1;
      bus.op       = 2'b00;
      bus.a        = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.b        = 64'd1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("rst_mid_valid", {63'b0, bus.out_valid}, 64'd0);
      chk("rst_mid_ready", {63'b0, bus.in_ready}, 64'd0);
      chk("rst_mid_sum", bus.sum, 64'd0);
      chk("rst_mid_flags", {60'b0, flags()}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
    end
    do_op("post_rst", 2'b00, 1'b0, 64'd1, 64'd1, mk(64'd2, 4'b0000), 0);

    chk("sb_drained", W'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
